// File: rtl/td4_sequencer.sv
// TD4 control unit: program counter, carry flag, instruction decode and a
// run/halt/single-step controller. Optional HLT opcode: define TD4_HALT_INSN_EN.
//
// Handshake/ordering contract with the datapath: EN marks a cycle whose
// instruction commits at the next rising CLK; LOAD strobes are only nonzero
// while EN is high, so a register may load on (EN & LOAD[n]) with no other
// qualification.

module td4_sequencer #(
   parameter int PC_W = 4
) (
   input  logic            CLK,
   input  logic            CLR,
   input  logic            RUN,
   input  logic            STEP,
   input  logic [7:0]      ROM_DATA,
   input  logic            CARRY_IN,
   output logic [PC_W-1:0] ROM_ADDR,
   output logic [3:0]      IM,
   output logic [1:0]      SEL,
   output logic [3:0]      LOAD,
   output logic            EN,
   output logic            C_FLAG,
   output logic            HALTED,
   output logic [1:0]      DBG_STATE
);

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_STEP = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [3:0] LD_A   = 4'b0001;
   localparam logic [3:0] LD_B   = 4'b0010;
   localparam logic [3:0] LD_OUT = 4'b0100;
   localparam logic [3:0] LD_PC  = 4'b1000;

   state_t          r_state;
   logic            r_en;
   logic            r_halted;
   logic            r_step_q;
   logic [PC_W-1:0] r_pc;
   logic            r_c;

   logic [3:0]      w_op;
   logic [3:0]      w_im;
   logic [1:0]      w_sel;
   logic [3:0]      w_dst;
   logic            w_hlt;
   logic            w_run_ok;
   logic            w_step_edge;

   assign w_op        = ROM_DATA[7:4];
   assign w_im        = ROM_DATA[3:0];
   assign w_step_edge = STEP && !r_step_q;

`ifdef TD4_HALT_INSN_EN
   logic r_armed;

   // After an HLT, RUN must be seen low once before it can restart the core.
   assign w_hlt    = (w_op == 4'b1000);
   assign w_run_ok = r_armed;
`else
   assign w_hlt    = 1'b0;
   assign w_run_ok = 1'b1;
`endif

   always_comb begin
      w_sel = 2'b11;
      w_dst = 4'b0000;
      case (w_op)
         4'b0000: begin w_sel = 2'b00; w_dst = LD_A;   end
         4'b0001: begin w_sel = 2'b01; w_dst = LD_A;   end
         4'b0010: begin w_sel = 2'b10; w_dst = LD_A;   end
         4'b0011: begin w_sel = 2'b11; w_dst = LD_A;   end
         4'b0100: begin w_sel = 2'b00; w_dst = LD_B;   end
         4'b0101: begin w_sel = 2'b01; w_dst = LD_B;   end
         4'b0110: begin w_sel = 2'b10; w_dst = LD_B;   end
         4'b0111: begin w_sel = 2'b11; w_dst = LD_B;   end
         4'b1001: begin w_sel = 2'b01; w_dst = LD_OUT; end
         4'b1011: begin w_sel = 2'b11; w_dst = LD_OUT; end
         // JNC looks at the carry left by the previously executed instruction.
         4'b1110: begin w_sel = 2'b11; w_dst = r_c ? 4'b0000 : LD_PC; end
         4'b1111: begin w_sel = 2'b11; w_dst = LD_PC;  end
         default: begin w_sel = 2'b11; w_dst = 4'b0000; end
      endcase
   end

   assign ROM_ADDR  = r_pc;
   assign IM        = w_im;
   assign SEL       = w_sel;
   assign LOAD      = r_en ? w_dst : 4'b0000;
   assign EN        = r_en;
   assign C_FLAG    = r_c;
   assign HALTED    = r_halted;
   assign DBG_STATE = r_state;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state  <= ST_HALT;
         r_en     <= 1'b0;
         r_halted <= 1'b1;
         r_step_q <= 1'b0;
         r_pc     <= '0;
         r_c      <= 1'b0;
`ifdef TD4_HALT_INSN_EN
         r_armed  <= 1'b1;
`endif
      end else begin
         r_step_q <= STEP;

         if (r_en) begin
            r_pc <= LOAD[3] ? PC_W'(w_im) : r_pc + PC_W'(1);
            r_c  <= CARRY_IN;
         end

`ifdef TD4_HALT_INSN_EN
         if (!RUN) begin
            r_armed <= 1'b1;
         end else if (r_en && w_hlt) begin
            r_armed <= 1'b0;
         end
`endif

         // EN/HALTED are registered alongside the state so they never glitch.
         case (r_state)
            ST_HALT: begin
               if (RUN && w_run_ok) begin
                  r_state  <= ST_RUN;
                  r_en     <= 1'b1;
                  r_halted <= 1'b0;
               end else if (w_step_edge) begin
                  r_state  <= ST_STEP;
                  r_en     <= 1'b1;
                  r_halted <= 1'b0;
               end
            end
            ST_STEP: begin
               r_state  <= ST_HALT;
               r_en     <= 1'b0;
               r_halted <= 1'b1;
            end
            ST_RUN: begin
               if (!RUN || w_hlt) begin
                  r_state  <= ST_HALT;
                  r_en     <= 1'b0;
                  r_halted <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_HALT;
               r_en     <= 1'b0;
               r_halted <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_td4_sequencer.sv
// Self-checking bench for td4_sequencer: directed scenarios then random
// ROM/RUN/STEP/reset traffic, compared against a per-instruction reference model.

module tb_td4_sequencer;

   logic       CLK;
   logic       CLR;
   logic       RUN;
   logic       STEP;
   logic [7:0] ROM_DATA;
   logic       CARRY_IN;
   logic [3:0] ROM_ADDR;
   logic [3:0] IM;
   logic [1:0] SEL;
   logic [3:0] LOAD;
   logic       EN;
   logic       C_FLAG;
   logic       HALTED;
   logic [1:0] DBG_STATE;

   logic [7:0] rom [16];
   logic       force_en;
   logic       force_val;
   logic       rnd_c;

   int checks = 0;
   int errors = 0;

   // Reference model state: what the machine should be doing this cycle.
   logic [3:0] m_pc;
   logic       m_c;
   logic       m_active;
   logic       m_one_shot;
   logic       m_armed;
   logic       m_prev_step;

   logic [1:0] sel_tab [16];
   logic [3:0] dst_tab [16];

   td4_sequencer #(.PC_W(4)) dut (
      .CLK(CLK), .CLR(CLR), .RUN(RUN), .STEP(STEP),
      .ROM_DATA(ROM_DATA), .CARRY_IN(CARRY_IN),
      .ROM_ADDR(ROM_ADDR), .IM(IM), .SEL(SEL), .LOAD(LOAD),
      .EN(EN), .C_FLAG(C_FLAG), .HALTED(HALTED), .DBG_STATE(DBG_STATE)
   );

   assign ROM_DATA = rom[ROM_ADDR];
   assign CARRY_IN = (force_en && ROM_ADDR == 4'd3) ? force_val : rnd_c;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check1(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic model_carry();
      return (force_en && m_pc == 4'd3) ? force_val : rnd_c;
   endfunction

   function automatic logic [3:0] model_load();
      logic [3:0] op;
      logic [3:0] d;
      op = rom[m_pc][7:4];
      d  = dst_tab[op];
      if (op == 4'd14 && m_c) d = 4'd0;
      return m_active ? d : 4'd0;
   endfunction

   task automatic reset_model();
      m_pc = 4'd0; m_c = 1'b0; m_active = 1'b0;
      m_one_shot = 1'b0; m_armed = 1'b1; m_prev_step = 1'b0;
   endtask

   task automatic check_outputs();
      logic [3:0] op;
      op = rom[m_pc][7:4];
      check1("addr",   8'(ROM_ADDR), 8'(m_pc));
      check1("im",     8'(IM),       8'(rom[m_pc][3:0]));
      check1("sel",    8'(SEL),      8'(sel_tab[op]));
      check1("load",   8'(LOAD),     8'(model_load()));
      check1("en",     8'(EN),       8'(m_active));
      check1("halted", 8'(HALTED),   8'(!m_active));
      check1("cflag",  8'(C_FLAG),   8'(m_c));
   endtask

   // Advance the model by one clock using the inputs presented this cycle.
   task automatic model_step();
      logic [3:0] op;
      logic [3:0] ld;
      logic       hlt;
      op  = rom[m_pc][7:4];
      ld  = model_load();
      hlt = 1'b0;
`ifdef TD4_HALT_INSN_EN
      hlt = m_active && (op == 4'd8);
`endif
      if (m_active) begin
         m_c  = model_carry();
         m_pc = ld[3] ? rom[m_pc][3:0] : 4'((m_pc + 1) % 16);
         if (m_one_shot || !RUN || hlt) begin
            m_active = 1'b0;
            m_one_shot = 1'b0;
         end
      end else if (RUN && m_armed) begin
         m_active = 1'b1;
         m_one_shot = 1'b0;
      end else if (STEP && !m_prev_step) begin
         m_active = 1'b1;
         m_one_shot = 1'b1;
      end
`ifdef TD4_HALT_INSN_EN
      if (!RUN) m_armed = 1'b1;
      else if (hlt) m_armed = 1'b0;
`endif
      m_prev_step = STEP;
   endtask

   task automatic cycle();
      @(negedge CLK);
      check_outputs();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      CLR = 1'b0;
      #1;
      check1("rst_en",     8'(EN),       8'd0);
      check1("rst_load",   8'(LOAD),     8'd0);
      check1("rst_halted", 8'(HALTED),   8'd1);
      check1("rst_addr",   8'(ROM_ADDR), 8'd0);
      check1("rst_cflag",  8'(C_FLAG),   8'd0);
      reset_model();
      #2;
      CLR = 1'b1;
   endtask

   task automatic fill_nop();
      for (int j = 0; j < 16; j++) rom[j] = 8'hC0;
   endtask

   initial begin
      sel_tab = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11,
                  2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
      dst_tab = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                  4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
      fill_nop();
      CLR = 1'b0; RUN = 1'b0; STEP = 1'b0;
      force_en = 1'b0; force_val = 1'b0; rnd_c = 1'b0;
      reset_model();

      #10;
      check1("init_halted", 8'(HALTED),   8'd1);
      check1("init_en",     8'(EN),       8'd0);
      check1("init_addr",   8'(ROM_ADDR), 8'd0);
      check1("init_load",   8'(LOAD),     8'd0);
      #13;
      CLR = 1'b1;
      @(posedge CLK);
      #1;
      repeat (10) cycle();

      // Single step, then a STEP held high for several cycles.
      rom[0] = 8'h35;
      STEP = 1'b1; cycle();
      STEP = 1'b0; repeat (3) cycle();
      check1("step_addr", 8'(ROM_ADDR), 8'd1);
      STEP = 1'b1; repeat (5) cycle();
      STEP = 1'b0; repeat (2) cycle();
      check1("step_hold_addr", 8'(ROM_ADDR), 8'd2);

      // Free-run through the wrap, then drop RUN while PC=7.
      do_reset();
      fill_nop();
      RUN = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i >= 17 && m_active && m_pc == 4'd7) RUN = 1'b0;
         cycle();
      end
      check1("run_stop_addr", 8'(ROM_ADDR), 8'd8);
      check1("run_stop_halt", 8'(HALTED),   8'd1);

      // JMP to 12.
      do_reset();
      fill_nop();
      rom[2] = 8'hFC;
      RUN = 1'b1;
      repeat (4) cycle();
      check1("jmp_addr", 8'(ROM_ADDR), 8'd12);
      RUN = 1'b0;
      repeat (2) cycle();

      // JNC not taken with carry set, taken with carry clear.
      for (int k = 0; k < 2; k++) begin
         do_reset();
         fill_nop();
         rom[3] = 8'h0F;
         rom[4] = 8'hE0;
         force_en = 1'b1;
         force_val = (k == 0);
         RUN = 1'b1;
         repeat (6) cycle();
         check1("jnc_addr", 8'(ROM_ADDR), (k == 0) ? 8'd5 : 8'd0);
         RUN = 1'b0;
         repeat (2) cycle();
         force_en = 1'b0;
      end

`ifdef TD4_HALT_INSN_EN
      do_reset();
      fill_nop();
      rom[6] = 8'h80;
      RUN = 1'b1;
      repeat (10) cycle();
      check1("hlt_halted", 8'(HALTED),   8'd1);
      check1("hlt_addr",   8'(ROM_ADDR), 8'd7);
      repeat (4) cycle();
      check1("hlt_stays", 8'(HALTED), 8'd1);
      RUN = 1'b0; cycle();
      RUN = 1'b1; repeat (3) cycle();
      check1("hlt_resume", 8'(HALTED), 8'd0);
`endif

      // Random program, control and carry traffic with occasional resets.
      for (int j = 0; j < 16; j++) rom[j] = 8'($urandom);
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(0, 99);
         rnd_c = 1'($urandom_range(0, 1));
         if (r < 6) RUN = ~RUN;
         else if (r < 20) STEP = ~STEP;
         else if (r == 20) do_reset();
         else if (r < 26) rom[$urandom_range(0, 15)] = 8'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
